// File: rtl/lsu_pkg.sv
// Shared types and default widths for the LSU memory port.
package lsu_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int TAG_W_DEF      = 4;
    localparam int RESP_DEPTH_DEF = 4;

    typedef struct packed {
        logic                  is_store;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
        logic [TAG_W_DEF-1:0]  tag;
    } lsu_req_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [TAG_W_DEF-1:0]  tag;
    } lsu_ld_t;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int cred_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lsu_fifo.sv
// Synchronous show-ahead FIFO: dout_o is the head entry whenever empty_o is low.
module lsu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push_i && full_o));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop_i && empty_o));

endmodule

// File: rtl/lsu_mem_port.sv
// LSU initiator port to the single-port memory. Credit-limited so every
// issued read has a guaranteed response-buffer slot.
// Optional feature: LSU_PERF_CNT_EN adds stat_loads/stat_stores/stat_stall counters.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int TAG_W      = TAG_W_DEF,
    parameter int RESP_DEPTH = RESP_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              ld_valid,
    input  logic              ld_ready,
    output logic [DATA_W-1:0] ld_data,
    output logic [TAG_W-1:0]  ld_tag,
    output logic              mem_rd_valid,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_resp,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_valid,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              err_spurious
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]       stat_loads,
    output logic [31:0]       stat_stores,
    output logic [31:0]       stat_stall
`endif
);

    localparam int CW = cred_w(RESP_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [TAG_W-1:0]  tag;
    } cmd_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } ld_t;

    logic [CW-1:0] credits_q, credits_d;
    cmd_t          cmd_q;
    logic          rd_v_q, wr_v_q, err_q;
    logic          accept, ld_acc, ld_pop, tag_pop;
    logic [TAG_W-1:0] tag_head;
    logic          tag_empty, tag_full, resp_empty, resp_full;
    ld_t           ld_head;

    assign req_ready = (credits_q != '0);
    assign accept    = req_valid && req_ready;
    assign ld_acc    = accept && !req_is_store;
    assign ld_pop    = ld_valid && ld_ready;
    assign tag_pop   = mem_rd_resp && !tag_empty;

    assign mem_rd_valid = rd_v_q;
    assign mem_wr_valid = wr_v_q;
    assign mem_rd_addr  = cmd_q.addr;
    assign mem_wr_addr  = cmd_q.addr;
    assign mem_wr_data  = cmd_q.wdata;
    assign err_spurious = err_q;

    assign ld_valid = !resp_empty;
    assign ld_data  = ld_head.data;
    assign ld_tag   = ld_head.tag;

    // Credits: a load takes a slot on accept, a consumer pop returns it.
    always_comb begin
        credits_d = credits_q;
        if (ld_acc && !ld_pop)      credits_d = credits_q - CW'(1);
        else if (!ld_acc && ld_pop) credits_d = credits_q + CW'(1);
    end

    // Credit register and one-cycle registered memory command.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits_q <= CW'(RESP_DEPTH);
            rd_v_q    <= 1'b0;
            wr_v_q    <= 1'b0;
            cmd_q     <= '0;
        end else begin
            credits_q <= credits_d;
            rd_v_q    <= ld_acc;
            wr_v_q    <= accept && req_is_store;
            if (accept) cmd_q <= '{addr: req_addr, wdata: req_wdata, tag: req_tag};
        end
    end

    // Sticky flag for a read response arriving with nothing outstanding.
    always_ff @(posedge clk) begin
        if (rst)                           err_q <= 1'b0;
        else if (mem_rd_resp && tag_empty) err_q <= 1'b1;
    end

    // Tags of reads issued to memory, consumed in order by responses.
    lsu_fifo #(.WIDTH(TAG_W), .DEPTH(RESP_DEPTH)) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rd_v_q),
        .din_i   (cmd_q.tag),
        .pop_i   (tag_pop),
        .dout_o  (tag_head),
        .empty_o (tag_empty),
        .full_o  (tag_full)
    );

    // Returned load data waiting for the consumer.
    lsu_fifo #(.WIDTH($bits(ld_t)), .DEPTH(RESP_DEPTH)) u_resp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tag_pop),
        .din_i   ({mem_rd_data, tag_head}),
        .pop_i   (ld_pop),
        .dout_o  (ld_head),
        .empty_o (resp_empty),
        .full_o  (resp_full)
    );

`ifdef LSU_PERF_CNT_EN
    logic [31:0] st_ld_q, st_st_q, st_stall_q;
    assign stat_loads  = st_ld_q;
    assign stat_stores = st_st_q;
    assign stat_stall  = st_stall_q;

    // Event counters; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_ld_q    <= '0;
            st_st_q    <= '0;
            st_stall_q <= '0;
        end else begin
            if (ld_acc)                   st_ld_q    <= st_ld_q + 32'd1;
            if (accept && req_is_store)   st_st_q    <= st_st_q + 32'd1;
            if (req_valid && !req_ready)  st_stall_q <= st_stall_q + 32'd1;
        end
    end
`endif

    a_cred_max:   assert property (@(posedge clk) disable iff (rst) credits_q <= CW'(RESP_DEPTH));
    a_cred_under: assert property (@(posedge clk) disable iff (rst) !(ld_acc && credits_q == '0));
    a_cred_over:  assert property (@(posedge clk) disable iff (rst)
                                   !(ld_pop && !ld_acc && credits_q == CW'(RESP_DEPTH)));
    a_tag_room:   assert property (@(posedge clk) disable iff (rst) !(rd_v_q && tag_full && !tag_pop));
    a_resp_room:  assert property (@(posedge clk) disable iff (rst) !(tag_pop && resp_full && !ld_pop));
    a_one_cmd:    assert property (@(posedge clk) disable iff (rst) !(rd_v_q && wr_v_q));

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port with a one-cycle-latency memory model and a load scoreboard.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_is_store = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_tag = '0;
    logic        ld_valid, ld_ready = 1'b0;
    logic [31:0] ld_data;
    logic [3:0]  ld_tag;
    logic        mem_rd_valid, mem_rd_resp, mem_wr_valid, err_spurious;
    logic [31:0] mem_rd_addr, mem_rd_data, mem_wr_addr, mem_wr_data;
    logic        inj = 1'b0;
`ifdef LSU_PERF_CNT_EN
    logic [31:0] stat_loads, stat_stores, stat_stall;
`endif

    always #5 clk = ~clk;

    lsu_mem_port dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_tag(ld_tag),
        .mem_rd_valid(mem_rd_valid), .mem_rd_addr(mem_rd_addr),
        .mem_rd_resp(mem_rd_resp), .mem_rd_data(mem_rd_data),
        .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .err_spurious(err_spurious)
`ifdef LSU_PERF_CNT_EN
        , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_stall(stat_stall)
`endif
    );

    function automatic logic [31:0] pat(input logic [7:0] i);
        return {24'hC0FFEE, i};
    endfunction

    // Memory model: one-cycle read latency, shares rst with the DUT.
    logic [31:0] mem [256];
    logic        model_resp;
    logic [31:0] model_data;
    always @(posedge clk) begin
        if (rst) begin
            model_resp <= 1'b0;
            model_data <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
        end else begin
            model_resp <= mem_rd_valid;
            if (mem_rd_valid) model_data <= mem[mem_rd_addr[7:0]];
            if (mem_wr_valid) mem[mem_wr_addr[7:0]] <= mem_wr_data;
        end
    end
    assign mem_rd_resp = model_resp | inj;
    assign mem_rd_data = model_data;

    int          n_chk = 0, n_fail = 0, rx_cnt = 0;
    logic [31:0] shadow [256];
    logic [35:0] sb [$];
    logic [35:0] exp_e;

    // Scoreboard: push expected {data,tag} on load accept, compare on pop.
    always @(negedge clk) begin
        if (rst) sb.delete();
        else begin
            if (req_valid && req_ready && !req_is_store)
                sb.push_back({shadow[req_addr[7:0]], req_tag});
            if (ld_valid && ld_ready) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL ld_unexpected: got data=%h tag=%0d, required no result", ld_data, ld_tag);
                end else begin
                    exp_e = sb.pop_front();
                    rx_cnt++;
                    if ({ld_data, ld_tag} !== exp_e) begin
                        n_fail++;
                        $display("FAIL ld_result: got data=%h tag=%0d, required data=%h tag=%0d",
                                 ld_data, ld_tag, exp_e[35:4], exp_e[3:0]);
                    end
                end
            end
            n_chk++;
            if (mem_rd_valid && mem_wr_valid) begin
                n_fail++;
                $display("FAIL one_cmd: got rd=1 wr=1, required at most one");
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 1'b0; inj = 1'b0;
        for (int i = 0; i < 256; i++) shadow[i] = pat(8'(i));
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic send(input bit st, input logic [31:0] a, input logic [31:0] d, input logic [3:0] t);
        int n = 0;
        req_valid = 1'b1; req_is_store = st; req_addr = a; req_wdata = d; req_tag = t;
        if (st) shadow[a[7:0]] = d;
        while (!req_ready && n < 200) begin tick(); n++; end
        n_chk++;
        if (!req_ready) begin
            n_fail++;
            $display("FAIL send_timeout: got req_ready=0 for %0d cycles, required 1", n);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin tick(); n++; end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_chk++; if (req_ready !== 1'b1)   begin n_fail++; $display("FAIL rst_ready: got %b required 1", req_ready); end
        n_chk++; if (ld_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_ld_valid: got %b required 0", ld_valid); end
        n_chk++; if ({mem_rd_valid, mem_wr_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_cmd: got %b required 00", {mem_rd_valid, mem_wr_valid}); end
        n_chk++; if (mem_rd_addr !== 32'h0 || mem_wr_data !== 32'h0) begin n_fail++; $display("FAIL rst_cmd_payload: got addr=%h data=%h required 0", mem_rd_addr, mem_wr_data); end
        n_chk++; if (err_spurious !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b required 0", err_spurious); end
`ifdef LSU_PERF_CNT_EN
        n_chk++; if ({stat_loads, stat_stores, stat_stall} !== 96'h0) begin n_fail++; $display("FAIL rst_stats: got %0d/%0d/%0d required 0/0/0", stat_loads, stat_stores, stat_stall); end
`endif
        tick();
    endtask

    task automatic test_store_load();
        ld_ready = 1'b1;
        send(1'b1, 32'h10, 32'hDEADBEEF, 4'd0);
        send(1'b0, 32'h10, 32'h0, 4'd3);
        @(negedge clk);
        n_chk++; if (mem_rd_valid !== 1'b1 || mem_rd_addr !== 32'h10) begin n_fail++; $display("FAIL sl_rd_cmd: got v=%b addr=%h required v=1 addr=00000010", mem_rd_valid, mem_rd_addr); end
        n_chk++; if (ld_valid !== 1'b0) begin n_fail++; $display("FAIL sl_early1: got ld_valid=%b required 0", ld_valid); end
        tick(); @(negedge clk);
        n_chk++; if (ld_valid !== 1'b0) begin n_fail++; $display("FAIL sl_early2: got ld_valid=%b required 0", ld_valid); end
        tick(); @(negedge clk);
        n_chk++; if (ld_valid !== 1'b1 || ld_data !== 32'hDEADBEEF || ld_tag !== 4'd3) begin
            n_fail++; $display("FAIL sl_result: got v=%b data=%h tag=%0d required v=1 data=deadbeef tag=3", ld_valid, ld_data, ld_tag);
        end
        tick();
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] d0;
        int rx0 = rx_cnt;
        ld_ready = 1'b0;
        for (int t = 0; t < 4; t++) send(1'b0, 32'h20 + t, 32'h0, 4'(t));
        @(negedge clk);
        n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b required 0", req_ready); end
        repeat (4) tick();
        @(negedge clk);
        d0 = ld_data;
        n_chk++; if (ld_valid !== 1'b1 || ld_tag !== 4'd0) begin n_fail++; $display("FAIL bp_head: got v=%b tag=%0d required v=1 tag=0", ld_valid, ld_tag); end
        tick(); @(negedge clk);
        n_chk++; if (ld_tag !== 4'd0 || ld_data !== d0 || ld_data !== pat(8'h20)) begin n_fail++; $display("FAIL bp_hold: got tag=%0d data=%h required tag=0 data=%h", ld_tag, ld_data, pat(8'h20)); end
        tick();
        ld_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_pre_pop_ready: got %b required 0", req_ready); end
        tick(); @(negedge clk);
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_post_pop_ready: got %b required 1", req_ready); end
        tick();
        drain();
        n_chk++; if (rx_cnt - rx0 != 4) begin n_fail++; $display("FAIL bp_count: got %0d required 4", rx_cnt - rx0); end
    endtask

    task automatic test_stream();
        int rx0 = rx_cnt;
        ld_ready = 1'b0;
        for (int t = 0; t < 4; t++) send(1'b0, 32'h30 + t, 32'h0, 4'(4 + t));
        repeat (4) tick();
        ld_ready = 1'b1;
        for (int t = 0; t < 8; t++) send(1'b0, 32'h38 + t, 32'h0, 4'(8 + t));
        drain();
        n_chk++; if (rx_cnt - rx0 != 12) begin n_fail++; $display("FAIL stream_count: got %0d required 12", rx_cnt - rx0); end
    endtask

    task automatic test_spurious();
        @(negedge clk);
        n_chk++; if (err_spurious !== 1'b0) begin n_fail++; $display("FAIL sp_pre: got %b required 0", err_spurious); end
        tick();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        @(negedge clk);
        n_chk++; if (err_spurious !== 1'b1 || ld_valid !== 1'b0) begin n_fail++; $display("FAIL sp_set: got err=%b ld_valid=%b required err=1 ld_valid=0", err_spurious, ld_valid); end
        repeat (3) begin
            tick(); @(negedge clk);
            n_chk++; if (err_spurious !== 1'b1 || ld_valid !== 1'b0) begin n_fail++; $display("FAIL sp_sticky: got err=%b ld_valid=%b required err=1 ld_valid=0", err_spurious, ld_valid); end
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        ld_ready = 1'b0;
        send(1'b0, 32'h40, 32'h0, 4'd1);
        send(1'b0, 32'h41, 32'h0, 4'd2);
        do_reset();
        @(negedge clk);
        n_chk++; if (req_ready !== 1'b1 || ld_valid !== 1'b0 || err_spurious !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst: got ready=%b ld_valid=%b err=%b required 1/0/0", req_ready, ld_valid, err_spurious);
        end
        repeat (5) begin
            tick(); @(negedge clk);
            n_chk++; if (ld_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_stale: got ld_valid=%b required 0", ld_valid); end
        end
        tick();
        ld_ready = 1'b1;
        send(1'b0, 32'h40, 32'h0, 4'd9);
        drain();
    endtask

`ifdef LSU_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        ld_ready = 1'b0;
        send(1'b1, 32'h50, 32'h11, 4'd0);
        send(1'b1, 32'h51, 32'h22, 4'd0);
        for (int t = 0; t < 3; t++) send(1'b0, 32'h50 + t, 32'h0, 4'(t));
        @(negedge clk);
        n_chk++; if (stat_loads !== 32'd3 || stat_stores !== 32'd2 || stat_stall !== 32'd0) begin
            n_fail++; $display("FAIL perf_a: got %0d/%0d/%0d required 3/2/0", stat_loads, stat_stores, stat_stall);
        end
        tick();
        send(1'b0, 32'h53, 32'h0, 4'd3);
        req_valid = 1'b1; req_is_store = 1'b0; req_addr = 32'h54; req_tag = 4'd4;
        repeat (5) tick();
        req_valid = 1'b0;
        @(negedge clk);
        n_chk++; if (stat_loads !== 32'd4 || stat_stores !== 32'd2 || stat_stall !== 32'd5) begin
            n_fail++; $display("FAIL perf_b: got %0d/%0d/%0d required 4/2/5", stat_loads, stat_stores, stat_stall);
        end
        tick();
        ld_ready = 1'b1;
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_store_load();
        test_backpressure();
        test_stream();
        test_spurious();
        test_reset_midflight();
`ifdef LSU_PERF_CNT_EN
        test_perf();
`endif
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
